bmem_arbiter: RTL and testbench
===============================

# bmem_arbiter

Parametrised burst-memory arbiter and line adapter between the core's caches (instruction, data, and later prefetch channels) and the single 64-bit burst memory port of the mp4 top level. Each channel issues whole-cacheline read or write requests. The block selects one channel round-robin, serialises the line into BEATS bursts on bmem, and returns a one-cycle response to the granted channel. It replaces the per-port magic-memory path used at CP1.

## Interface
Parameters:
- NUM_PORTS, 2, number of requesting channels (≥1)
- LINE_WIDTH, 256, cacheline width in bits
- BMEM_WIDTH, 64, burst beat width in bits; BEATS = LINE_WIDTH/BMEM_WIDTH (integer, ≥2)

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- req_address  in  NUM_PORTS×32  per-channel byte address (low log2(LINE_WIDTH/8) bits ignored)
- req_read  in  NUM_PORTS  per-channel line read request, held until rsp_resp
- req_write  in  NUM_PORTS  per-channel line write request, held until rsp_resp
- req_wdata  in  NUM_PORTS×LINE_WIDTH  per-channel write line, held stable while requesting
- rsp_rdata  out  LINE_WIDTH  read line, shared; valid only in the rsp_resp cycle
- rsp_resp  out  NUM_PORTS  one-hot completion pulse to the granted channel
- bmem_address  out  32  line-aligned burst address
- bmem_read  out  1  burst read request
- bmem_write  out  1  burst write request
- bmem_wdata  out  BMEM_WIDTH  current write beat
- bmem_rdata  in  BMEM_WIDTH  read beat, valid when bmem_resp
- bmem_resp  in  1  beat accepted (write) / beat valid (read)

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE: a channel is pending if req_read|req_write. Pick the first pending channel starting at pointer ptr and wrapping modulo NUM_PORTS. Register the grant index, the aligned address and the wdata. Go to WRITE if req_write, else READ. Read and write together on one channel is treated as a write. Zero pending channels: stay in IDLE.
- ptr ← (grant+1) mod NUM_PORTS on every grant, so fairness holds under continuous contention.
- READ: bmem_read=1, bmem_address held. Each bmem_resp stores bmem_rdata into beat[cnt] = bits [cnt*BMEM_WIDTH +: BMEM_WIDTH] and increments cnt. The memory may leave gaps between beats. The resp on cnt=BEATS-1 moves the FSM to DONE.
- WRITE: bmem_write=1, bmem_wdata = registered line beat[cnt], beat 0 first. Each bmem_resp accepts the current beat and increments cnt. The resp on the last beat moves the FSM to DONE.
- DONE: rsp_resp[grant]=1 for exactly one cycle and rsp_rdata = assembled line (reads; writes drive the last-read line, don't-care). cnt←0. Next state is IDLE.
- A requester deasserting mid-transaction does not abort it. The burst completes and the resp pulse is still issued.
- bmem_resp in IDLE or DONE is ignored.
- cnt is $clog2(BEATS) bits and wraps to 0 only via DONE.

## Timing
- Reset, synchronous: state=IDLE, ptr=0, cnt=0. All outputs 0: bmem_read, bmem_write, bmem_address, bmem_wdata, rsp_resp, rsp_rdata. rst mid-burst abandons the burst on the next edge, and the memory model is reset alongside.
- Outputs are registered or state-decoded only. There is no combinational path from req_* or bmem_resp to any output.
- Request visible in IDLE at cycle t → bmem_read/bmem_write high from t+1.
- Last bmem_resp at cycle u → rsp_resp high at u+1 only. The earliest next grant evaluation is at u+2 (IDLE), so the next burst starts at u+3.
- Minimum read latency, with memory returning beats on consecutive cycles starting at t+L: rsp_resp at t+L+BEATS.
- The granted channel must still hold its request in DONE. It drops the request at the cycle after rsp_resp, otherwise it is regranted.

## Test plan
- Single read, ch0, addr 0x0000_1234, beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 → bmem_address=0x0000_1220, rsp_resp=2'b01 for one cycle, rsp_rdata = {0x44..,0x33..,0x22..,0x11..}.
- Single write, ch1, line 0xDDDD…_CCCC…_BBBB…_AAAA… → bmem_wdata sequence AAAA…, BBBB…, CCCC…, DDDD…, one per bmem_resp, with gaps honoured; rsp_resp=2'b10.
- Both channels request continuously from reset → grants alternate ch0, ch1, ch0, ch1; no channel is granted twice in a row.
- Read beats with 3-cycle gaps between bmem_resp → bmem_read held throughout, beats assembled in order, a single rsp_resp.
- rst asserted after beat 2 of a read → next cycle all outputs 0, state IDLE; the re-issued request completes normally with ptr restarted at 0.
- NUM_PORTS=3, LINE_WIDTH=512: ch2 write of 8 beats → exactly 8 accepted beats, rsp_resp=3'b100; ptr then favours ch0.

Source files
------------

// File: rtl/bmem_arbiter.sv
// Round-robin arbiter that serialises whole-cacheline read/write requests from
// several cache channels onto one burst memory port, BEATS beats per line.
module bmem_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int LINE_WIDTH = 256,
  parameter int BMEM_WIDTH = 64
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_PORTS-1:0][31:0]           req_address,
  input  logic [NUM_PORTS-1:0]                 req_read,
  input  logic [NUM_PORTS-1:0]                 req_write,
  input  logic [NUM_PORTS-1:0][LINE_WIDTH-1:0] req_wdata,
  output logic [LINE_WIDTH-1:0]                rsp_rdata,
  output logic [NUM_PORTS-1:0]                 rsp_resp,
  output logic [31:0]                          bmem_address,
  output logic                                 bmem_read,
  output logic                                 bmem_write,
  output logic [BMEM_WIDTH-1:0]                bmem_wdata,
  input  logic [BMEM_WIDTH-1:0]                bmem_rdata,
  input  logic                                 bmem_resp
);

  localparam int          BEATS     = LINE_WIDTH / BMEM_WIDTH;
  localparam int          CNT_W     = $clog2(BEATS);
  localparam int          PTR_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [31:0] ADDR_MASK = ~(32'(LINE_WIDTH / 8) - 32'd1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                 r_state;
  logic [PTR_W-1:0]       r_ptr;
  logic [PTR_W-1:0]       r_grant;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_bmem_read;
  logic                   r_bmem_write;
  logic [NUM_PORTS-1:0]   r_rsp;
  logic [31:0]            r_addr;
  logic [LINE_WIDTH-1:0]  r_wline;
  logic [LINE_WIDTH-1:0]  r_rline;

  logic [NUM_PORTS-1:0]   w_pend;
  logic                   w_found;
  logic [PTR_W-1:0]       w_gidx;
  logic                   w_last;

  function automatic logic [PTR_W-1:0] wrap_idx(input int base, input int off);
    return PTR_W'((base + off) % NUM_PORTS);
  endfunction

  assign w_pend = req_read | req_write;
  assign w_last = (r_cnt == CNT_W'(BEATS - 1));

  // First pending channel at or after the pointer, wrapping around.
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!w_found && w_pend[wrap_idx(int'(r_ptr), i)]) begin
        w_found = 1'b1;
        w_gidx  = wrap_idx(int'(r_ptr), i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_ptr        <= '0;
      r_grant      <= '0;
      r_cnt        <= '0;
      r_bmem_read  <= 1'b0;
      r_bmem_write <= 1'b0;
      r_rsp        <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_grant <= w_gidx;
            r_ptr   <= wrap_idx(int'(w_gidx), 1);
            if (req_write[w_gidx]) begin
              r_state      <= WRITE;
              r_bmem_write <= 1'b1;
            end else begin
              r_state     <= READ;
              r_bmem_read <= 1'b1;
            end
          end
        end
        READ: begin
          if (bmem_resp) begin
            if (w_last) begin
              r_state     <= DONE;
              r_bmem_read <= 1'b0;
              r_rsp       <= NUM_PORTS'(1) << r_grant;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        WRITE: begin
          if (bmem_resp) begin
            if (w_last) begin
              r_state      <= DONE;
              r_bmem_write <= 1'b0;
              r_rsp        <= NUM_PORTS'(1) << r_grant;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_rsp   <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Line datapath: no reset, outputs below are gated by the registered controls.
  always_ff @(posedge clk) begin
    if (r_state == IDLE && w_found) begin
      r_addr  <= req_address[w_gidx];
      r_wline <= req_wdata[w_gidx];
    end
    if (r_state == READ && bmem_resp) begin
      r_rline[int'(r_cnt) * BMEM_WIDTH +: BMEM_WIDTH] <= bmem_rdata;
    end
  end

  assign bmem_read    = r_bmem_read;
  assign bmem_write   = r_bmem_write;
  assign rsp_resp     = r_rsp;
  assign bmem_address = (r_bmem_read | r_bmem_write) ? (r_addr & ADDR_MASK) : '0;
  assign bmem_wdata   = r_bmem_write ? r_wline[int'(r_cnt) * BMEM_WIDTH +: BMEM_WIDTH] : '0;
  assign rsp_rdata    = (|r_rsp) ? r_rline : '0;

endmodule

// File: tb/tb_bmem_arbiter.sv
// Directed bench for bmem_arbiter: a 2-port/256-bit instance and a 3-port/512-bit instance.
module tb_bmem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [1:0][31:0]  a2;
  logic [1:0]        rd2, wr2, resp2;
  logic [1:0][255:0] wd2;
  logic [255:0]      rdata2;
  logic [31:0]       baddr2;
  logic              bread2, bwrite2, bresp2;
  logic [63:0]       bwd2, brd2;

  logic [2:0][31:0]  a3;
  logic [2:0]        rd3, wr3, resp3;
  logic [2:0][511:0] wd3;
  logic [511:0]      rdata3;
  logic [31:0]       baddr3;
  logic              bread3, bwrite3, bresp3;
  logic [63:0]       bwd3, brd3;

  bmem_arbiter #(.NUM_PORTS(2), .LINE_WIDTH(256), .BMEM_WIDTH(64)) dut2 (
    .clk(clk), .rst(rst), .req_address(a2), .req_read(rd2), .req_write(wr2),
    .req_wdata(wd2), .rsp_rdata(rdata2), .rsp_resp(resp2), .bmem_address(baddr2),
    .bmem_read(bread2), .bmem_write(bwrite2), .bmem_wdata(bwd2),
    .bmem_rdata(brd2), .bmem_resp(bresp2));

  bmem_arbiter #(.NUM_PORTS(3), .LINE_WIDTH(512), .BMEM_WIDTH(64)) dut3 (
    .clk(clk), .rst(rst), .req_address(a3), .req_read(rd3), .req_write(wr3),
    .req_wdata(wd3), .rsp_rdata(rdata3), .rsp_resp(resp3), .bmem_address(baddr3),
    .bmem_read(bread3), .bmem_write(bwrite3), .bmem_wdata(bwd3),
    .bmem_rdata(brd3), .bmem_resp(bresp3));

  task automatic chk(input string tag, input bit ok, input logic [511:0] obs, input logic [511:0] exp);
    n_assert++;
    assert (ok) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_burst2(input int gap, input logic [1:0] exp_resp,
                           input logic [255:0] line, input string tag);
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < gap; g++) begin
        bresp2 = 1'b0;
        step();
        chk({tag, "_gap_read"}, bread2 === 1'b1, bread2, 1'b1);
        chk({tag, "_gap_resp"}, resp2 === 2'b00, resp2, 2'b00);
      end
      bresp2 = 1'b1;
      brd2   = line[k*64 +: 64];
      step();
      bresp2 = 1'b0;
      if (k < 3) chk({tag, "_mid_resp"}, resp2 === 2'b00, resp2, 2'b00);
    end
    chk({tag, "_resp"}, resp2 === exp_resp, resp2, exp_resp);
    chk({tag, "_rdata"}, rdata2 === line, rdata2, line);
    chk({tag, "_read_low"}, bread2 === 1'b0, bread2, 1'b0);
  endtask

  logic [255:0] L1, L2, L3, L4;
  logic [511:0] L6;
  logic [31:0]  exp_addr;
  logic [63:0]  exp_beat;

  initial begin
    L1 = {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111};
    L2 = {64'hDDDDDDDDDDDDDDDD, 64'hCCCCCCCCCCCCCCCC, 64'hBBBBBBBBBBBBBBBB, 64'hAAAAAAAAAAAAAAAA};
    L3 = {64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'h5555AAAA5555AAAA, 64'h0F0F0F0F0F0F0F0F};
    L4 = {64'h8000000000000001, 64'h7FFFFFFFFFFFFFFE, 64'h00000000FFFFFFFF, 64'hFFFFFFFF00000000};
    for (int k = 0; k < 8; k++) L6[k*64 +: 64] = {32'hC0DE0000 + 32'(k), 32'h5EED0000 + 32'(k)};

    a2 = '0; rd2 = '0; wr2 = '0; wd2 = '0; bresp2 = 1'b0; brd2 = '0;
    a3 = '0; rd3 = '0; wr3 = '0; wd3 = '0; bresp3 = 1'b0; brd3 = '0;
    rst = 1'b1;
    step();
    step();
    chk("rst_read", bread2 === 1'b0, bread2, 1'b0);
    chk("rst_write", bwrite2 === 1'b0, bwrite2, 1'b0);
    chk("rst_addr", baddr2 === 32'h0, baddr2, 32'h0);
    chk("rst_wdata", bwd2 === 64'h0, bwd2, 64'h0);
    chk("rst_resp", resp2 === 2'b00, resp2, 2'b00);
    chk("rst_rdata", rdata2 === 256'h0, rdata2, 256'h0);
    chk("rst3_rdata", rdata3 === 512'h0, rdata3, 512'h0);
    chk("rst3_resp", resp3 === 3'b000, resp3, 3'b000);
    rst = 1'b0;

    // Single read on ch0
    a2[0] = 32'h0000_1234;
    rd2[0] = 1'b1;
    step();
    chk("t1_read", bread2 === 1'b1, bread2, 1'b1);
    chk("t1_write", bwrite2 === 1'b0, bwrite2, 1'b0);
    chk("t1_addr", baddr2 === 32'h0000_1220, baddr2, 32'h0000_1220);
    rd_burst2(0, 2'b01, L1, "t1");
    rd2[0] = 1'b0;
    step();
    chk("t1_resp_once", resp2 === 2'b00, resp2, 2'b00);
    chk("t1_rdata_clr", rdata2 === 256'h0, rdata2, 256'h0);

    // Single write on ch1 with one idle cycle before every accepted beat
    a2[1]  = 32'h0000_4040;
    wd2[1] = L2;
    wr2[1] = 1'b1;
    step();
    chk("t2_write", bwrite2 === 1'b1, bwrite2, 1'b1);
    chk("t2_read", bread2 === 1'b0, bread2, 1'b0);
    chk("t2_addr", baddr2 === 32'h0000_4040, baddr2, 32'h0000_4040);
    for (int k = 0; k < 4; k++) begin
      exp_beat = L2[k*64 +: 64];
      chk("t2_wdata", bwd2 === exp_beat, bwd2, exp_beat);
      bresp2 = 1'b0;
      step();
      chk("t2_wdata_gap", bwd2 === exp_beat, bwd2, exp_beat);
      bresp2 = 1'b1;
      step();
      bresp2 = 1'b0;
      if (k < 3) chk("t2_mid_resp", resp2 === 2'b00, resp2, 2'b00);
    end
    chk("t2_resp", resp2 === 2'b10, resp2, 2'b10);
    chk("t2_write_low", bwrite2 === 1'b0, bwrite2, 1'b0);
    wr2[1] = 1'b0;

    // Continuous contention: grants alternate ch0, ch1, ch0, ch1
    a2[0] = 32'h0000_0100;
    a2[1] = 32'h0000_2000;
    rd2   = 2'b11;
    step();
    for (int g = 0; g < 4; g++) begin
      step();
      exp_addr = (g % 2 == 1) ? 32'h0000_2000 : 32'h0000_0100;
      chk("t3_addr", baddr2 === exp_addr, baddr2, exp_addr);
      chk("t3_read", bread2 === 1'b1, bread2, 1'b1);
      rd_burst2(0, (g % 2 == 1) ? 2'b10 : 2'b01, L1, "t3");
      step();
    end
    rd2 = 2'b01;

    // Read with 3-cycle gaps between beats
    step();
    chk("t4_addr", baddr2 === 32'h0000_0100, baddr2, 32'h0000_0100);
    rd_burst2(3, 2'b01, L3, "t4");
    rd2[0] = 1'b0;
    step();
    chk("t4_resp_once", resp2 === 2'b00, resp2, 2'b00);
    step();
    chk("t4_idle_read", bread2 === 1'b0, bread2, 1'b0);
    chk("t4_idle_resp", resp2 === 2'b00, resp2, 2'b00);

    // Reset after beat 2 of a ch0 read; pointer must restart at ch0
    a2[0] = 32'h0000_0500;
    rd2[0] = 1'b1;
    step();
    chk("t5_addr", baddr2 === 32'h0000_0500, baddr2, 32'h0000_0500);
    bresp2 = 1'b1;
    brd2   = 64'hDEADBEEFDEADBEEF;
    step();
    step();
    bresp2 = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_rst_read", bread2 === 1'b0, bread2, 1'b0);
    chk("t5_rst_write", bwrite2 === 1'b0, bwrite2, 1'b0);
    chk("t5_rst_addr", baddr2 === 32'h0, baddr2, 32'h0);
    chk("t5_rst_wdata", bwd2 === 64'h0, bwd2, 64'h0);
    chk("t5_rst_resp", resp2 === 2'b00, resp2, 2'b00);
    chk("t5_rst_rdata", rdata2 === 256'h0, rdata2, 256'h0);
    a2[1]  = 32'h0000_0600;
    rd2    = 2'b11;
    bresp2 = 1'b1;
    step();
    bresp2 = 1'b0;
    chk("t5_regrant_addr", baddr2 === 32'h0000_0500, baddr2, 32'h0000_0500);
    chk("t5_regrant_read", bread2 === 1'b1, bread2, 1'b1);
    rd_burst2(0, 2'b01, L4, "t5");
    rd2 = 2'b00;
    step();

    // 3-port, 8-beat write on ch2
    a3[2]  = 32'h0001_0047;
    wd3[2] = L6;
    wr3[2] = 1'b1;
    step();
    chk("t6_write", bwrite3 === 1'b1, bwrite3, 1'b1);
    chk("t6_addr", baddr3 === 32'h0001_0040, baddr3, 32'h0001_0040);
    for (int k = 0; k < 8; k++) begin
      exp_beat = {32'hC0DE0000 + 32'(k), 32'h5EED0000 + 32'(k)};
      chk("t6_wdata", bwd3 === exp_beat, bwd3, exp_beat);
      bresp3 = 1'b1;
      step();
      bresp3 = 1'b0;
      if (k < 7) chk("t6_mid_resp", resp3 === 3'b000, resp3, 3'b000);
    end
    chk("t6_resp", resp3 === 3'b100, resp3, 3'b100);
    chk("t6_write_low", bwrite3 === 1'b0, bwrite3, 1'b0);
    wr3[2] = 1'b0;
    a3[0]  = 32'h0000_0200;
    a3[2]  = 32'h0000_0300;
    rd3    = 3'b101;
    step();
    step();
    chk("t6_next_grant_addr", baddr3 === 32'h0000_0200, baddr3, 32'h0000_0200);
    chk("t6_next_grant_read", bread3 === 1'b1, bread3, 1'b1);
    rd3 = 3'b000;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
